// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and downstream hold.
// Optional performance counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_ex_stall,
  input  logic            i_id_vld,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [31:0]     i_id_instr,
  input  logic [XLEN-1:0] i_id_rs1_data,
  input  logic [XLEN-1:0] i_id_rs2_data,
  input  logic [XLEN-1:0] i_id_imm,
  input  logic            i_pc_sel,
  input  logic            i_rd_wren,
  input  logic            i_insn_vld,
  input  logic            i_br_un,
  input  logic            i_opa_sel,
  input  logic            i_opb_sel,
  input  logic            i_mem_wren,
  input  logic            i_ld_un,
  input  logic [3:0]      i_alu_op,
  input  logic [1:0]      i_wb_sel,
  input  logic [1:0]      i_lsu_op,
  output logic            o_ex_vld,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [XLEN-1:0] o_ex_rs1_data,
  output logic [XLEN-1:0] o_ex_rs2_data,
  output logic [XLEN-1:0] o_ex_imm,
  output logic [4:0]      o_ex_rs1,
  output logic [4:0]      o_ex_rs2,
  output logic [4:0]      o_ex_rd,
  output logic            o_ex_pc_sel,
  output logic            o_ex_rd_wren,
  output logic            o_ex_insn_vld,
  output logic            o_ex_br_un,
  output logic            o_ex_opa_sel,
  output logic            o_ex_opb_sel,
  output logic            o_ex_mem_wren,
  output logic            o_ex_ld_un,
  output logic [3:0]      o_ex_alu_op,
  output logic [1:0]      o_ex_wb_sel,
  output logic [1:0]      o_ex_lsu_op,
  output logic            o_stall_id,
  output logic [31:0]     o_bubble_cnt,
  output logic [31:0]     o_flush_cnt
);

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            pc_sel;
    logic            rd_wren;
    logic            insn_vld;
    logic            br_un;
    logic            opa_sel;
    logic            opb_sel;
    logic            mem_wren;
    logic            ld_un;
    logic [3:0]      alu_op;
    logic [1:0]      wb_sel;
    logic [1:0]      lsu_op;
  } ex_t;

  typedef enum logic [1:0] {RUN, HOLD, BUBBLE} mode_e;

  localparam logic [1:0] WB_LSU = 2'b10;

  ex_t   ex_q, ex_d;
  mode_e mode;
  logic  hazard;

  wire [4:0] id_rs1 = i_id_instr[19:15];
  wire [4:0] id_rs2 = i_id_instr[24:20];
  wire [4:0] id_rd  = i_id_instr[11:7];

  // Conservative: rs1/rs2 compared whether or not the ID instruction reads them.
  assign hazard = i_id_vld & ex_q.vld & (ex_q.wb_sel == WB_LSU) & (ex_q.rd != 5'd0) &
                  ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

  assign o_stall_id = (hazard | i_ex_stall) & ~i_flush;

  always_comb begin
    mode = RUN;
    if (i_flush)         mode = BUBBLE;
    else if (i_ex_stall) mode = HOLD;
    else if (hazard)     mode = BUBBLE;
  end

  always_comb begin
    ex_d = '0;
    case (mode)
      HOLD: ex_d = ex_q;
      RUN: if (i_id_vld) begin
        ex_d.vld      = 1'b1;
        ex_d.pc       = i_id_pc;
        ex_d.rs1_data = i_id_rs1_data;
        ex_d.rs2_data = i_id_rs2_data;
        ex_d.imm      = i_id_imm;
        ex_d.rs1      = id_rs1;
        ex_d.rs2      = id_rs2;
        ex_d.rd       = id_rd;
        ex_d.pc_sel   = i_pc_sel;
        ex_d.rd_wren  = i_rd_wren;
        ex_d.insn_vld = i_insn_vld;
        ex_d.br_un    = i_br_un;
        ex_d.opa_sel  = i_opa_sel;
        ex_d.opb_sel  = i_opb_sel;
        ex_d.mem_wren = i_mem_wren;
        ex_d.ld_un    = i_ld_un;
        ex_d.alu_op   = i_alu_op;
        ex_d.wb_sel   = i_wb_sel;
        ex_d.lsu_op   = i_lsu_op;
      end
      default: ex_d = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) ex_q <= '0;
    else         ex_q <= ex_d;
  end

  assign o_ex_vld      = ex_q.vld;
  assign o_ex_pc       = ex_q.pc;
  assign o_ex_rs1_data = ex_q.rs1_data;
  assign o_ex_rs2_data = ex_q.rs2_data;
  assign o_ex_imm      = ex_q.imm;
  assign o_ex_rs1      = ex_q.rs1;
  assign o_ex_rs2      = ex_q.rs2;
  assign o_ex_rd       = ex_q.rd;
  assign o_ex_pc_sel   = ex_q.pc_sel;
  assign o_ex_rd_wren  = ex_q.rd_wren;
  assign o_ex_insn_vld = ex_q.insn_vld;
  assign o_ex_br_un    = ex_q.br_un;
  assign o_ex_opa_sel  = ex_q.opa_sel;
  assign o_ex_opb_sel  = ex_q.opb_sel;
  assign o_ex_mem_wren = ex_q.mem_wren;
  assign o_ex_ld_un    = ex_q.ld_un;
  assign o_ex_alu_op   = ex_q.alu_op;
  assign o_ex_wb_sel   = ex_q.wb_sel;
  assign o_ex_lsu_op   = ex_q.lsu_op;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, flush_cnt_q;

  // A flush-induced bubble is counted as a flush only, never as a hazard bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (mode == BUBBLE && !i_flush) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (i_flush && i_id_vld)        flush_cnt_q  <= flush_cnt_q + 32'd1;
    end
  end

  assign o_bubble_cnt = bubble_cnt_q;
  assign o_flush_cnt  = flush_cnt_q;
`else
  assign o_bubble_cnt = '0;
  assign o_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against a cycle-level reference model.
module tb_id_ex_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_reset, i_flush, i_ex_stall, i_id_vld;
  logic [XLEN-1:0] i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm;
  logic [31:0]     i_id_instr;
  logic i_pc_sel, i_rd_wren, i_insn_vld, i_br_un, i_opa_sel, i_opb_sel, i_mem_wren, i_ld_un;
  logic [3:0] i_alu_op;
  logic [1:0] i_wb_sel, i_lsu_op;

  logic            o_ex_vld;
  logic [XLEN-1:0] o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm;
  logic [4:0]      o_ex_rs1, o_ex_rs2, o_ex_rd;
  logic o_ex_pc_sel, o_ex_rd_wren, o_ex_insn_vld, o_ex_br_un, o_ex_opa_sel, o_ex_opb_sel, o_ex_mem_wren, o_ex_ld_un;
  logic [3:0]  o_ex_alu_op;
  logic [1:0]  o_ex_wb_sel, o_ex_lsu_op;
  logic        o_stall_id;
  logic [31:0] o_bubble_cnt, o_flush_cnt;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush), .i_ex_stall(i_ex_stall),
    .i_id_vld(i_id_vld), .i_id_pc(i_id_pc), .i_id_instr(i_id_instr),
    .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data), .i_id_imm(i_id_imm),
    .i_pc_sel(i_pc_sel), .i_rd_wren(i_rd_wren), .i_insn_vld(i_insn_vld), .i_br_un(i_br_un),
    .i_opa_sel(i_opa_sel), .i_opb_sel(i_opb_sel), .i_mem_wren(i_mem_wren), .i_ld_un(i_ld_un),
    .i_alu_op(i_alu_op), .i_wb_sel(i_wb_sel), .i_lsu_op(i_lsu_op),
    .o_ex_vld(o_ex_vld), .o_ex_pc(o_ex_pc), .o_ex_rs1_data(o_ex_rs1_data),
    .o_ex_rs2_data(o_ex_rs2_data), .o_ex_imm(o_ex_imm),
    .o_ex_rs1(o_ex_rs1), .o_ex_rs2(o_ex_rs2), .o_ex_rd(o_ex_rd),
    .o_ex_pc_sel(o_ex_pc_sel), .o_ex_rd_wren(o_ex_rd_wren), .o_ex_insn_vld(o_ex_insn_vld),
    .o_ex_br_un(o_ex_br_un), .o_ex_opa_sel(o_ex_opa_sel), .o_ex_opb_sel(o_ex_opb_sel),
    .o_ex_mem_wren(o_ex_mem_wren), .o_ex_ld_un(o_ex_ld_un), .o_ex_alu_op(o_ex_alu_op),
    .o_ex_wb_sel(o_ex_wb_sel), .o_ex_lsu_op(o_ex_lsu_op),
    .o_stall_id(o_stall_id), .o_bubble_cnt(o_bubble_cnt), .o_flush_cnt(o_flush_cnt)
  );

  typedef struct packed {
    logic vld;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0] rs1, rs2, rd;
    logic pc_sel, rd_wren, insn_vld, br_un, opa_sel, opb_sel, mem_wren, ld_un;
    logic [3:0] alu_op;
    logic [1:0] wb_sel, lsu_op;
  } word_t;

  int n_cmp = 0, n_bad = 0;
  word_t m;
  logic [31:0] m_bcnt = '0, m_fcnt = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic word_t dut_word();
    return {o_ex_vld, o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm, o_ex_rs1, o_ex_rs2, o_ex_rd,
            o_ex_pc_sel, o_ex_rd_wren, o_ex_insn_vld, o_ex_br_un, o_ex_opa_sel, o_ex_opb_sel,
            o_ex_mem_wren, o_ex_ld_un, o_ex_alu_op, o_ex_wb_sel, o_ex_lsu_op};
  endfunction

  function automatic word_t id_word();
    return {1'b1, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
            i_id_instr[19:15], i_id_instr[24:20], i_id_instr[11:7],
            i_pc_sel, i_rd_wren, i_insn_vld, i_br_un, i_opa_sel, i_opb_sel, i_mem_wren, i_ld_un,
            i_alu_op, i_wb_sel, i_lsu_op};
  endfunction

  // Load in EX writing a non-zero register that ID names as a source.
  function automatic logic load_use();
    return i_id_vld && m.vld && m.wb_sel == 2'b10 && m.rd != 0 &&
           (m.rd == i_id_instr[19:15] || m.rd == i_id_instr[24:20]);
  endfunction

  function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    return {7'($urandom), rs2, rs1, 3'($urandom), rd, 7'($urandom)};
  endfunction

  task automatic rand_id();
    i_id_vld      = ($urandom_range(0, 9) < 8);
    i_id_pc       = $urandom & 32'hFFFF_FFFC;
    i_id_instr    = mk_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    i_id_rs1_data = $urandom;
    i_id_rs2_data = $urandom;
    i_id_imm      = $urandom;
    {i_pc_sel, i_rd_wren, i_insn_vld, i_br_un, i_opa_sel, i_opb_sel, i_mem_wren, i_ld_un} = 8'($urandom);
    i_alu_op = 4'($urandom);
    i_wb_sel = 2'($urandom);
    i_lsu_op = 2'($urandom);
  endtask

  // Called just after an edge with new inputs applied; checks stall, advances one edge, checks EX.
  task automatic step();
    logic stall_exp;
    #1;
    stall_exp = (load_use() || i_ex_stall) && !i_flush;
    chk("stall_id", o_stall_id, stall_exp);
    if (i_reset) begin
      m = '0; m_bcnt = 0; m_fcnt = 0;
    end else if (i_flush) begin
      if (i_id_vld) m_fcnt++;
      m = '0;
    end else if (i_ex_stall) begin
      m = m;
    end else if (load_use()) begin
      m_bcnt++;
      m = '0;
    end else begin
      m = i_id_vld ? id_word() : '0;
    end
    @(posedge clk);
    #1;
    chk("ex_word", dut_word(), m);
`ifdef ID_EX_PERF_CNT_EN
    chk("bubble_cnt", o_bubble_cnt, m_bcnt);
    chk("flush_cnt", o_flush_cnt, m_fcnt);
`else
    chk("bubble_cnt_off", o_bubble_cnt, 32'd0);
    chk("flush_cnt_off", o_flush_cnt, 32'd0);
`endif
  endtask

  task automatic set_load(input logic [4:0] rd);
    rand_id();
    i_id_vld = 1; i_insn_vld = 1; i_rd_wren = 1; i_mem_wren = 0;
    i_wb_sel = 2'b10; i_id_instr = mk_instr(5'd2, 5'd0, rd);
  endtask

  logic [31:0] pc_keep, b0, f0;

  initial begin
    m = '0;
    rand_id();
    i_reset = 1; i_flush = 0; i_ex_stall = 0; i_id_vld = 1; i_id_pc = 32'h100;
    @(posedge clk); #1;
    // Reset held with a valid ID instruction.
    step(); step();
    chk("rst_vld", o_ex_vld, 1'b0);
    chk("rst_stall", o_stall_id, 1'b0);
    i_reset = 0; i_id_vld = 1; i_id_pc = 32'h100;
    step();
    chk("rst_first_pc", o_ex_pc, 32'h100);

    // Load-use: lw x5 then add x6,x5,x1.
    set_load(5'd5); step();
    b0 = m_bcnt;
    rand_id(); i_id_vld = 1; i_wb_sel = 2'b01; i_id_pc = 32'h200; i_id_instr = mk_instr(5'd5, 5'd1, 5'd6);
    #1 chk("lu_stall", o_stall_id, 1'b1);
    step();
    chk("lu_bubble", o_ex_vld, 1'b0);
    chk("lu_stall_drop", o_stall_id, 1'b0);
    step();
    chk("lu_add_pc", o_ex_pc, 32'h200);
    chk("lu_add_vld", o_ex_vld, 1'b1);
    chk("lu_bcnt_delta", m_bcnt - b0, 32'd1);

    // Load into x0 followed by a use of x0.
    set_load(5'd0); step();
    rand_id(); i_id_vld = 1; i_id_instr = mk_instr(5'd0, 5'd0, 5'd7);
    #1 chk("x0_no_stall", o_stall_id, 1'b0);
    step();
    chk("x0_loaded", o_ex_vld, 1'b1);

    // Flush beats stall and hazard.
    set_load(5'd9); step();
    b0 = m_bcnt; f0 = m_fcnt;
    rand_id(); i_id_vld = 1; i_id_instr = mk_instr(5'd9, 5'd9, 5'd3);
    i_flush = 1; i_ex_stall = 1;
    #1 chk("fl_stall", o_stall_id, 1'b0);
    step();
    chk("fl_vld", o_ex_vld, 1'b0);
    chk("fl_fcnt_delta", m_fcnt - f0, 32'd1);
    chk("fl_bcnt_same", m_bcnt - b0, 32'd0);
    i_flush = 0; i_ex_stall = 0;

    // Downstream hold for 3 cycles.
    rand_id(); i_id_vld = 1; i_wb_sel = 2'b01; step();
    pc_keep = o_ex_pc;
    i_ex_stall = 1;
    for (int k = 0; k < 3; k++) begin
      rand_id();
      step();
      chk("hold_pc", o_ex_pc, pc_keep);
      chk("hold_stall", o_stall_id, 1'b1);
    end
    i_ex_stall = 0; rand_id(); i_id_vld = 1; i_id_pc = 32'h400;
    step();
    chk("hold_release_pc", o_ex_pc, 32'h400);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rand_id();
      i_reset    = ($urandom_range(0, 99) < 2);
      i_flush    = ($urandom_range(0, 99) < 10);
      i_ex_stall = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 3) == 0) i_wb_sel = 2'b10;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
